// File: rtl/hdmi_i2c_arbiter.sv
// hdmi_i2c_arbiter: shares one I2C byte controller between two register-level
// requesters. Each grant covers one full register write or one register read
// using a repeated START. Requesters are served round-robin, with an idle gap
// enforced between transactions.
module hdmi_i2c_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd2000000,
    parameter logic [7:0]  GAP     = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rw,
    input  logic [7:0] req0_dev,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic       req0_err,
    output logic [7:0] req0_rdata,
    input  logic       req1_valid,
    input  logic       req1_rw,
    input  logic [7:0] req1_dev,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic       req1_err,
    output logic [7:0] req1_rdata,
    output logic       i2c_start,
    output logic       i2c_stop,
    output logic       i2c_read,
    output logic       i2c_write,
    output logic       i2c_ack_out,
    output logic [7:0] i2c_dout,
    input  logic       i2c_done,
    input  logic       i2c_ack_in,
    input  logic [7:0] i2c_din,
    input  logic       i2c_al,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEV    = 3'd1,
        S_REG    = 3'd2,
        S_RSTART = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_ESTOP  = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    // Command word layout: {start, stop, read, write, ack_out}
    localparam logic [4:0] CMD_NONE  = 5'b00000;
    localparam logic [4:0] CMD_SW    = 5'b10010;  // START + WRITE
    localparam logic [4:0] CMD_W     = 5'b00010;  // WRITE
    localparam logic [4:0] CMD_WP    = 5'b01010;  // WRITE + STOP
    localparam logic [4:0] CMD_RPN   = 5'b01101;  // READ + STOP, master NACK
    localparam logic [4:0] CMD_P     = 5'b01000;  // STOP alone

    state_t      state_q, state_d;
    logic        last_q, last_d;      // last granted requester
    logic        cur_q, cur_d;        // current owner of the bus
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;        // 7-bit device address (R/W bit dropped)
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [7:0]  dout_q, dout_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic [23:0] tmo_q, tmo_d;
    logic [7:0]  gap_q, gap_d;

    logic        gnt;                 // requester chosen in IDLE
    logic        fin;                 // transaction ends this cycle
    logic        fin_err;             // error status of that ending

    // Next-state logic: arbitration, command sequencing, timeout and gap count
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cur_d    = cur_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        cmd_d    = cmd_q;
        dout_d   = dout_q;
        ready_d  = 2'b00;
        done_d   = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        gnt      = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt = ~last_q;
                end else begin
                    gnt = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    cur_d        = gnt;
                    last_d       = gnt;
                    rw_d         = gnt ? req1_rw       : req0_rw;
                    dev_d        = gnt ? req1_dev[7:1] : req0_dev[7:1];
                    reg_d        = gnt ? req1_reg      : req0_reg;
                    wdata_d      = gnt ? req1_wdata    : req0_wdata;
                    ready_d[gnt] = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_DEV;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GAP: begin
                if (gap_q >= GAP - 8'd1) begin
                    gap_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                if (i2c_al) begin
                    // Lost the bus: the controller has released it, no STOP.
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (cmd_q == CMD_NONE) begin
                    // Only DEV is entered without a command already loaded.
                    cmd_d  = CMD_SW;
                    dout_d = {dev_q, 1'b0};
                    tmo_d  = 24'd0;
                end else if (i2c_done) begin
                    tmo_d = 24'd0;
                    case (state_q)
                        S_DEV, S_REG, S_RSTART: begin
                            if (i2c_ack_in) begin
                                cmd_d   = CMD_P;
                                dout_d  = 8'd0;
                                state_d = S_ESTOP;
                            end else if (state_q == S_DEV) begin
                                cmd_d   = CMD_W;
                                dout_d  = reg_q;
                                state_d = S_REG;
                            end else if (state_q == S_RSTART) begin
                                cmd_d   = CMD_RPN;
                                dout_d  = 8'd0;
                                state_d = S_RDATA;
                            end else if (rw_q) begin
                                cmd_d   = CMD_SW;
                                dout_d  = {dev_q, 1'b1};
                                state_d = S_RSTART;
                            end else begin
                                cmd_d   = CMD_WP;
                                dout_d  = wdata_q;
                                state_d = S_WDATA;
                            end
                        end
                        S_RDATA: begin
                            if (cur_q) begin
                                rdata1_d = i2c_din;
                            end else begin
                                rdata0_d = i2c_din;
                            end
                            fin = 1'b1;
                        end
                        S_WDATA: begin
                            // STOP already went out with this byte.
                            fin     = 1'b1;
                            fin_err = i2c_ack_in;
                        end
                        S_ESTOP: begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end
                        default: begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end
                    endcase
                end else if (tmo_q >= TIMEOUT - 24'd1) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end

                if (fin) begin
                    cmd_d          = CMD_NONE;
                    dout_d         = 8'd0;
                    done_d[cur_q]  = 1'b1;
                    err_d[cur_q]   = fin_err;
                    gap_d          = 8'd0;
                    tmo_d          = 24'd0;
                    state_d        = S_GAP;
                end else begin
                    gap_d = gap_q;
                end
            end
        endcase
    end

    // State and registered outputs, with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cur_q    <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            wdata_q  <= 8'd0;
            cmd_q    <= CMD_NONE;
            dout_q   <= 8'd0;
            ready_q  <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 8'd0;
            rdata1_q <= 8'd0;
            busy_q   <= 1'b0;
            tmo_q    <= 24'd0;
            gap_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            cmd_q    <= cmd_d;
            dout_q   <= dout_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
        end
    end

    assign req0_ready  = ready_q[0];
    assign req1_ready  = ready_q[1];
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign i2c_start   = cmd_q[4];
    assign i2c_stop    = cmd_q[3];
    assign i2c_read    = cmd_q[2];
    assign i2c_write   = cmd_q[1];
    assign i2c_ack_out = cmd_q[0];
    assign i2c_dout    = dout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hdmi_i2c_arbiter.sv
// Bench for hdmi_i2c_arbiter: directed scenarios plus randomized transactions.
// A byte-controller responder answers each command; expected command streams,
// status and timing come from the transaction rules, not from the RTL.
module tb_hdmi_i2c_arbiter;

    localparam int GAP_C = 8;
    localparam int TMO_C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] f_valid;
    logic       f_rw [2];
    logic [7:0] f_dev [2];
    logic [7:0] f_reg [2];
    logic [7:0] f_wd [2];
    logic       req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out;
    logic [7:0] i2c_dout;
    logic       i2c_done, i2c_ack_in, i2c_al;
    logic [7:0] i2c_din;
    logic       busy;
    logic [4:0] cmd_w;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rdata [2];
    logic       last_m;

    assign cmd_w = {i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out};

    always #5 clk = ~clk;

    hdmi_i2c_arbiter #(.TIMEOUT(24'd16), .GAP(8'd8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(f_valid[0]), .req0_rw(f_rw[0]), .req0_dev(f_dev[0]),
        .req0_reg(f_reg[0]), .req0_wdata(f_wd[0]),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
        .req0_rdata(req0_rdata),
        .req1_valid(f_valid[1]), .req1_rw(f_rw[1]), .req1_dev(f_dev[1]),
        .req1_reg(f_reg[1]), .req1_wdata(f_wd[1]),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
        .req1_rdata(req1_rdata),
        .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_read(i2c_read),
        .i2c_write(i2c_write), .i2c_ack_out(i2c_ack_out), .i2c_dout(i2c_dout),
        .i2c_done(i2c_done), .i2c_ack_in(i2c_ack_in), .i2c_din(i2c_din),
        .i2c_al(i2c_al), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: the requester not granted last wins a tie.
    function automatic logic winner(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

    task automatic expect_grant(input logic id);
        chk("ready0", {31'd0, req0_ready}, {31'd0, id == 1'b0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, id == 1'b1});
        chk("busy_at_grant", {31'd0, busy}, 32'd1);
        last_m = id;
    endtask

    task automatic request(input logic id);
        f_valid[id] = 1'b1;
        tick;
        expect_grant(id);
        f_valid[id] = 1'b0;
    endtask

    task automatic respond(input logic done_b, input logic al_b, input logic nack_b,
                           input logic [7:0] din);
        i2c_done   = done_b;
        i2c_al     = al_b;
        i2c_ack_in = nack_b;
        i2c_din    = din;
        tick;
        i2c_done   = 1'b0;
        i2c_al     = 1'b0;
        i2c_ack_in = 1'b0;
        i2c_din    = 8'($urandom);
    endtask

    // Serve one granted transaction. fk: 0 ok, 1 NACK, 2 arbitration lost,
    // 3 timeout; fi is the index of the faulty command. Starts on the ready
    // cycle, ends on the first cycle after the gap (busy low).
    task automatic serve(input logic id, input int fk, input int fi, input logic [7:0] rd);
        logic [4:0] cmds [$];
        logic [7:0] douts [$];
        int         lat;
        cmds = {};
        douts = {};
        cmds.push_back(5'b10010); douts.push_back({f_dev[id][7:1], 1'b0});
        cmds.push_back(5'b00010); douts.push_back(f_reg[id]);
        if (f_rw[id]) begin
            cmds.push_back(5'b10010); douts.push_back({f_dev[id][7:1], 1'b1});
            cmds.push_back(5'b01101); douts.push_back(8'h00);
        end else begin
            cmds.push_back(5'b01010); douts.push_back(f_wd[id]);
        end
        tick;
        for (int k = 0; k < cmds.size(); k++) begin
            chk("cmd", {27'd0, cmd_w}, {27'd0, cmds[k]});
            if (cmds[k][1]) chk("dout", {24'd0, i2c_dout}, {24'd0, douts[k]});
            if (fk == 3 && k == fi) begin
                repeat (TMO_C - 1) tick;
                chk("tmo_hold", {27'd0, cmd_w}, {27'd0, cmds[k]});
                tick;
                chk("tmo_clear", {27'd0, cmd_w}, 32'd0);
                break;
            end
            lat = $urandom_range(0, 5);
            repeat (lat) tick;
            chk("cmd_stable", {27'd0, cmd_w}, {27'd0, cmds[k]});
            respond(!(fk == 2 && k == fi), fk == 2 && k == fi, fk == 1 && k == fi, rd);
            if (fk == 2 && k == fi) begin
                chk("al_clear", {27'd0, cmd_w}, 32'd0);
                break;
            end
            if (fk == 1 && k == fi) begin
                if (k != cmds.size() - 1) begin
                    chk("estop_cmd", {27'd0, cmd_w}, 32'b01000);
                    respond(1'b1, 1'b0, 1'b0, rd);
                end
                chk("end_clear", {27'd0, cmd_w}, 32'd0);
                break;
            end
        end
        if (f_rw[id] && fk == 0) exp_rdata[id] = rd;
        chk("done0", {31'd0, req0_done}, {31'd0, id == 1'b0});
        chk("done1", {31'd0, req1_done}, {31'd0, id == 1'b1});
        chk("err", {31'd0, id ? req1_err : req0_err}, {31'd0, fk != 0});
        chk("rdata0", {24'd0, req0_rdata}, {24'd0, exp_rdata[0]});
        chk("rdata1", {24'd0, req1_rdata}, {24'd0, exp_rdata[1]});
        tick;
        chk("done_pulse", {30'd0, req1_done, req0_done}, 32'd0);
        repeat (GAP_C - 2) tick;
        chk("busy_gap_end", {31'd0, busy}, 32'd1);
        tick;
        chk("busy_clear", {31'd0, busy}, 32'd0);
        chk("idle_cmd", {27'd0, cmd_w}, 32'd0);
    endtask

    task automatic set_req(input logic id, input logic rw, input logic [7:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        f_rw[id]  = rw;
        f_dev[id] = dev;
        f_reg[id] = rg;
        f_wd[id]  = wd;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd"}, {27'd0, cmd_w}, 32'd0);
        chk({tag, "_dout"}, {24'd0, i2c_dout}, 32'd0);
        chk({tag, "_flags"}, {25'd0, busy, req1_ready, req0_ready, req1_done, req0_done,
                              req1_err, req0_err}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, req1_rdata, req0_rdata}, 32'd0);
    endtask

    initial begin
        logic       w;
        logic       id;
        int         fk, fi;
        f_valid    = 2'b00;
        i2c_done   = 1'b0;
        i2c_al     = 1'b0;
        i2c_ack_in = 1'b0;
        i2c_din    = 8'h00;
        for (int i = 0; i < 2; i++) begin
            set_req(i[0], 1'b0, 8'h00, 8'h00, 8'h00);
            exp_rdata[i] = 8'h00;
        end
        last_m = 1'b1;
        reset  = 1'b1;
        repeat (3) tick;
        check_reset_state("reset");
        reset = 1'b0;
        tick;

        // Register write by requester 0
        set_req(1'b0, 1'b0, 8'h98, 8'h41, 8'h10);
        request(1'b0);
        serve(1'b0, 0, 0, 8'h00);

        // Register read by requester 1
        set_req(1'b1, 1'b1, 8'h98, 8'h96, 8'h00);
        request(1'b1);
        serve(1'b1, 0, 0, 8'h80);

        // Contention: both held valid, grants alternate starting with 0
        last_m = 1'b1;
        set_req(1'b0, 1'b0, 8'h98, 8'h20, 8'h5a);
        set_req(1'b1, 1'b0, 8'h72, 8'h30, 8'ha5);
        f_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            w = winner(f_valid[0], f_valid[1], last_m);
            tick;
            expect_grant(w);
            if (g == 3) f_valid = 2'b00;
            serve(w, 0, 0, 8'h00);
        end

        // NACK on device byte: STOP alone, err
        set_req(1'b0, 1'b0, 8'h98, 8'h41, 8'h10);
        request(1'b0);
        serve(1'b0, 1, 0, 8'h00);

        // Arbitration lost during register byte
        set_req(1'b1, 1'b1, 8'h98, 8'h11, 8'h00);
        request(1'b1);
        serve(1'b1, 2, 1, 8'h00);

        // Timeout on device byte
        set_req(1'b0, 1'b1, 8'hA0, 8'h00, 8'h00);
        request(1'b0);
        serve(1'b0, 3, 0, 8'h00);

        // NACK on the write-data byte: STOP already issued, no extra STOP
        set_req(1'b1, 1'b0, 8'h98, 8'h05, 8'h77);
        request(1'b1);
        serve(1'b1, 1, 2, 8'h00);

        // Successful read so rdata1 is non-zero before the reset test
        set_req(1'b1, 1'b1, 8'h98, 8'h07, 8'h00);
        request(1'b1);
        serve(1'b1, 0, 0, 8'h3c);

        // Reset during RDATA
        set_req(1'b1, 1'b1, 8'h98, 8'h96, 8'h00);
        request(1'b1);
        tick;
        for (int k = 0; k < 3; k++) begin
            respond(1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("rdata_cmd", {27'd0, cmd_w}, 32'b01101);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset_state("midreset");
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        last_m = 1'b1;
        tick;
        chk("no_done_after_reset", {29'd0, busy, req1_done, req0_done}, 32'd0);
        request(1'b1);
        serve(1'b1, 0, 0, 8'hc3);

        // Randomized transactions with random faults
        for (int t = 0; t < 12; t++) begin
            id = 1'($urandom_range(0, 1));
            set_req(id, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            fk = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            fi = (fk == 1) ? $urandom_range(0, 2) : $urandom_range(0, f_rw[id] ? 3 : 2);
            request(id);
            serve(id, fk, fi, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
